// File: rtl/ifm_window_reader_if.sv
// Signal bundle for the IFM window reader: frame configuration, buffer read port
// and the window output stream. The reader itself uses the slave view.
interface ifm_window_reader_if #(
    parameter int PE = 16
);
    logic            start;
    logic [15:0]     IFM_C;
    logic [15:0]     IFM_W;
    logic            padding;
    logic            stride;
    logic            row_done;

    logic            rd_en;
    logic [31:0]     rd_addr;
    logic [PE*8-1:0] rd_data;

    logic [PE*8-1:0] win_data;
    logic            win_valid;
    logic            win_ready;
    logic            win_last_k;
    logic            win_last;

    logic            busy;
    logic            done;

    modport slave (
        input  start, IFM_C, IFM_W, padding, stride, row_done, rd_data, win_ready,
        output rd_en, rd_addr, win_data, win_valid, win_last_k, win_last, busy, done
    );

    modport master (
        output start, IFM_C, IFM_W, padding, stride, row_done, rd_data, win_ready,
        input  rd_en, rd_addr, win_data, win_valid, win_last_k, win_last, busy, done
    );
endinterface

// File: rtl/ifm_window_reader.sv
// Walks 3x3 convolution windows over a padded IFM buffer, gated by committed rows,
// and streams the fetched words through a 2-entry output FIFO.
module ifm_window_reader #(
    parameter int PE = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    ifm_window_reader_if.slave bus
);
    localparam int DW = PE * 8;

    typedef enum logic [2:0] {IDLE, WAIT_ROWS, ISSUE, DRAIN, DONE} state_e;

    state_e        state_q, state_d;

    logic [15:0]   cw_q;
    logic          stride_q;
    logic [16:0]   wp_q;
    logic [16:0]   ho_q;
    logic [16:0]   rows_q;

    logic [16:0]   oy_q;
    logic [16:0]   ox_q;
    logic [15:0]   c_q;
    logic [1:0]    ky_q;
    logic [1:0]    kx_q;

    logic          inflight_q;
    logic          inflight_last_k_q;
    logic          inflight_last_q;

    logic [DW-1:0] fifo_data_q   [2];
    logic          fifo_last_k_q [2];
    logic          fifo_last_q   [2];
    logic          wr_ptr_q;
    logic          rd_ptr_q;
    logic [1:0]    count_q, count_d;

    logic [15:0]   cfg_cw;
    logic [16:0]   cfg_wp;
    logic [16:0]   cfg_ho;
    logic          cfg_ok;
    logic          start_acc;

    logic [31:0]   oy_s;
    logic [31:0]   ox_s;
    logic [31:0]   row_idx;
    logic [31:0]   col_idx;
    logic [31:0]   word_idx;
    logic [31:0]   rows_need;
    logic          rows_ok;

    logic          last_k_tap;
    logic          final_tap;
    logic          space_ok;
    logic          issue;
    logic          push;
    logic          pop;
    logic          head_last;

    // Configuration decode; a frame with fewer than 3 padded rows or no channel words has no windows.
    assign cfg_cw    = 16'(bus.IFM_C / 16'(PE));
    assign cfg_wp    = {1'b0, bus.IFM_W} + (bus.padding ? 17'd2 : 17'd0);
    assign cfg_ho    = (cfg_wp >= 17'd3) ? (((cfg_wp - 17'd3) >> bus.stride) + 17'd1) : 17'd0;
    assign cfg_ok    = (cfg_wp >= 17'd3) && (cfg_cw != 16'd0);
    assign start_acc = bus.start && (state_q == IDLE);

    assign oy_s      = stride_q ? {14'd0, oy_q, 1'b0} : {15'd0, oy_q};
    assign ox_s      = stride_q ? {14'd0, ox_q, 1'b0} : {15'd0, ox_q};
    assign row_idx   = oy_s + {30'd0, ky_q};
    assign col_idx   = ox_s + {30'd0, kx_q};
    assign word_idx  = (row_idx * {15'd0, wp_q} + col_idx) * {16'd0, cw_q} + {16'd0, c_q};
    assign rows_need = oy_s + 32'd3;
    assign rows_ok   = ({15'd0, rows_q} >= rows_need);

    assign last_k_tap = (ky_q == 2'd2) && (kx_q == 2'd2);
    assign final_tap  = last_k_tap && (c_q == cw_q - 16'd1) &&
                        (ox_q == ho_q - 17'd1) && (oy_q == ho_q - 17'd1);

    // A read is only issued when its returning word is guaranteed a FIFO slot.
    assign space_ok  = ({1'b0, count_q} + {2'b00, inflight_q}) < 3'd2;
    assign push      = inflight_q;
    assign pop       = (count_q != 2'd0) && bus.win_ready;
    assign head_last = fifo_last_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = cfg_ok ? WAIT_ROWS : DONE;
                end
            end
            WAIT_ROWS: begin
                if (rows_ok) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (!rows_ok) begin
                    state_d = WAIT_ROWS;
                end else if (space_ok) begin
                    issue = 1'b1;
                    if (final_tap) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop && head_last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Window counters advance kx fastest, then ky, cw, ox, oy; they wrap to zero after the final tap.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            cw_q     <= 16'd0;
            stride_q <= 1'b0;
            wp_q     <= 17'd0;
            ho_q     <= 17'd0;
            rows_q   <= 17'd0;
            oy_q     <= 17'd0;
            ox_q     <= 17'd0;
            c_q      <= 16'd0;
            ky_q     <= 2'd0;
            kx_q     <= 2'd0;
        end else if (start_acc) begin
            cw_q     <= cfg_cw;
            stride_q <= bus.stride;
            wp_q     <= cfg_wp;
            ho_q     <= cfg_ho;
            rows_q   <= (bus.row_done && (cfg_wp != 17'd0)) ? 17'd1 : 17'd0;
            oy_q     <= 17'd0;
            ox_q     <= 17'd0;
            c_q      <= 16'd0;
            ky_q     <= 2'd0;
            kx_q     <= 2'd0;
        end else begin
            if (bus.row_done && (state_q != IDLE) && (rows_q < wp_q)) begin
                rows_q <= rows_q + 17'd1;
            end
            if (issue) begin
                if (kx_q != 2'd2) begin
                    kx_q <= kx_q + 2'd1;
                end else begin
                    kx_q <= 2'd0;
                    if (ky_q != 2'd2) begin
                        ky_q <= ky_q + 2'd1;
                    end else begin
                        ky_q <= 2'd0;
                        if (c_q != cw_q - 16'd1) begin
                            c_q <= c_q + 16'd1;
                        end else begin
                            c_q <= 16'd0;
                            if (ox_q != ho_q - 17'd1) begin
                                ox_q <= ox_q + 17'd1;
                            end else begin
                                ox_q <= 17'd0;
                                oy_q <= (oy_q != ho_q - 17'd1) ? oy_q + 17'd1 : 17'd0;
                            end
                        end
                    end
                end
            end
        end
    end

    // Tags travel with each read so the returning word lands in the FIFO with its markers.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            inflight_q        <= 1'b0;
            inflight_last_k_q <= 1'b0;
            inflight_last_q   <= 1'b0;
        end else begin
            inflight_q        <= issue;
            inflight_last_k_q <= issue && last_k_tap;
            inflight_last_q   <= issue && final_tap;
        end
    end

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 2'd1;
        end else if (!push && pop) begin
            count_d = count_q - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 2; i++) begin
                fifo_data_q[i]   <= '0;
                fifo_last_k_q[i] <= 1'b0;
                fifo_last_q[i]   <= 1'b0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                fifo_data_q[wr_ptr_q]   <= bus.rd_data;
                fifo_last_k_q[wr_ptr_q] <= inflight_last_k_q;
                fifo_last_q[wr_ptr_q]   <= inflight_last_q;
                wr_ptr_q                <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
        end
    end

    assign bus.rd_en      = issue;
    assign bus.rd_addr    = {word_idx[29:0], 2'b00};
    assign bus.win_valid  = (count_q != 2'd0);
    assign bus.win_data   = fifo_data_q[rd_ptr_q];
    assign bus.win_last_k = fifo_last_k_q[rd_ptr_q];
    assign bus.win_last   = fifo_last_q[rd_ptr_q];
    assign bus.busy       = (state_q != IDLE);
    assign bus.done       = (state_q == DONE);
endmodule

// File: tb/tb_ifm_window_reader.sv
// Directed bench for ifm_window_reader: a frame-level model of the read order and a
// word-returning buffer, checked against the DUT every cycle.
module tb_ifm_window_reader;
    localparam int PE = 16;

    logic clk;
    logic rst_n;

    ifm_window_reader_if #(.PE(PE)) bus();

    ifm_window_reader #(.PE(PE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          checks;
    int          errors;
    int          cycle;

    logic [31:0] expAddr [512];
    int          expOy   [512];
    bit          expLk   [512];
    logic [31:0] obsAddr [512];
    int          expCount;
    int          modelS;

    int          issueIdx;
    int          outIdx;
    int          occ;
    int          rowsSent;
    int          startCycle;
    int          lastCycle;
    int          lastWordIdx;
    int          doneCnt;
    int          readyMode;
    bit          trackEn;
    bit          doneSeen;
    bit          rdEn1;
    bit          rdEn2;
    bit          popPrev;
    bit          prevStall;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        cycle = 0;
        forever begin
            @(posedge clk);
            cycle++;
        end
    end

    function automatic logic [127:0] memWord(input logic [31:0] a);
        return {a ^ 32'hDEADBEEF, ~a, a + 32'h12345678, a};
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected read sequence from the frame geometry, outermost oy down to kx.
    task automatic buildModel(input int c, input int w, input int p, input int s);
        int cwN;
        int wp;
        int ho;
        int sN;
        cwN      = c / PE;
        sN       = s + 1;
        wp       = w + 2 * p;
        ho       = (wp >= 3) ? (wp - 3) / sN + 1 : 0;
        modelS   = sN;
        expCount = 0;
        if (wp >= 3 && cwN > 0) begin
            for (int oy = 0; oy < ho; oy++)
                for (int ox = 0; ox < ho; ox++)
                    for (int ch = 0; ch < cwN; ch++)
                        for (int ky = 0; ky < 3; ky++)
                            for (int kx = 0; kx < 3; kx++) begin
                                expAddr[expCount] = 32'(4 * (((oy * sN + ky) * wp + ox * sN + kx) * cwN + ch));
                                expOy[expCount]   = oy;
                                expLk[expCount]   = (ky == 2) && (kx == 2);
                                expCount++;
                            end
        end
    endtask

    task automatic applyStimulus(input int c, input int w, input int p, input int s, input bit rowWithStart);
        buildModel(c, w, p, s);
        issueIdx    = 0;
        outIdx      = 0;
        occ         = 0;
        rdEn1       = 1'b0;
        rdEn2       = 1'b0;
        popPrev     = 1'b0;
        prevStall   = 1'b0;
        doneSeen    = 1'b0;
        doneCnt     = 0;
        lastCycle   = -10;
        lastWordIdx = -1;
        rowsSent    = rowWithStart ? 1 : 0;
        trackEn     = 1'b1;
        bus.IFM_C    = 16'(c);
        bus.IFM_W    = 16'(w);
        bus.padding  = 1'(p);
        bus.stride   = 1'(s);
        bus.start    = 1'b1;
        bus.row_done = rowWithStart;
        startCycle   = cycle;
        tick();
        bus.start    = 1'b0;
        bus.row_done = 1'b0;
        bus.IFM_C    = 16'hFFFF;
        bus.IFM_W    = 16'd2;
        bus.padding  = 1'b0;
        bus.stride   = 1'b1;
    endtask

    task automatic sendRows(input int n);
        for (int i = 0; i < n; i++) begin
            bus.row_done = 1'b1;
            rowsSent++;
            tick();
            bus.row_done = 1'b0;
            tick();
        end
    endtask

    task automatic waitDone(input int maxCycles);
        int n;
        n = 0;
        while (!doneSeen && n < maxCycles) begin
            @(posedge clk);
            n++;
        end
        if (!doneSeen) begin
            checks++;
            errors++;
            $display("[TB] FAIL done_timeout: no done within %0d cycles, words seen %0d of %0d", maxCycles, outIdx, expCount);
        end
        repeat (3) @(negedge clk);
        checkOutput("done_count", 128'(doneCnt), 128'(1));
        checkOutput("busy_after_done", 128'(bus.busy), 128'(0));
        tick();
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_rd_en"},      128'(bus.rd_en),      128'(0));
        checkOutput({tag, "_rd_addr"},    128'(bus.rd_addr),    128'(0));
        checkOutput({tag, "_win_valid"},  128'(bus.win_valid),  128'(0));
        checkOutput({tag, "_win_data"},   128'(bus.win_data),   128'(0));
        checkOutput({tag, "_win_last_k"}, 128'(bus.win_last_k), 128'(0));
        checkOutput({tag, "_win_last"},   128'(bus.win_last),   128'(0));
        checkOutput({tag, "_busy"},       128'(bus.busy),       128'(0));
        checkOutput({tag, "_done"},       128'(bus.done),       128'(0));
    endtask

    // Buffer emulation: a word requested in one cycle is presented for the whole next cycle.
    initial begin
        bit          pend;
        logic [31:0] pendAddr;
        bus.rd_data = '0;
        forever begin
            @(negedge clk);
            pend     = bus.rd_en;
            pendAddr = bus.rd_addr;
            @(posedge clk);
            #1;
            bus.rd_data = pend ? memWord(pendAddr) : {$urandom, $urandom, $urandom, $urandom};
        end
    end

    initial begin
        bus.win_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.win_ready = (readyMode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        end
    end

    // Per-cycle comparison of reads, FIFO occupancy, window words and done timing against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (trackEn) begin
                occ = occ + (rdEn2 ? 1 : 0) - (popPrev ? 1 : 0);
                checkOutput("win_valid", 128'(bus.win_valid), 128'(occ > 0));
                checkOutput("occupancy_bound", 128'((occ + (rdEn1 ? 1 : 0) + (bus.rd_en ? 1 : 0)) <= 2), 128'(1));
                if (prevStall) begin
                    checkOutput("stall_valid", 128'(bus.win_valid), 128'(1));
                end
                if (bus.rd_en) begin
                    if (issueIdx < expCount) begin
                        checkOutput("rd_addr", 128'(bus.rd_addr), 128'(expAddr[issueIdx]));
                        checkOutput("row_gate", 128'(rowsSent >= expOy[issueIdx] * modelS + 3), 128'(1));
                        obsAddr[issueIdx] = bus.rd_addr;
                    end else begin
                        checkOutput("extra_read", 128'(issueIdx), 128'(expCount - 1));
                    end
                    issueIdx++;
                end
                if (bus.win_valid) begin
                    if (outIdx < expCount) begin
                        checkOutput("win_data",   bus.win_data,          memWord(expAddr[outIdx]));
                        checkOutput("win_last_k", 128'(bus.win_last_k),  128'(expLk[outIdx]));
                        checkOutput("win_last",   128'(bus.win_last),    128'(outIdx == expCount - 1));
                    end else begin
                        checkOutput("extra_word", 128'(outIdx), 128'(expCount - 1));
                    end
                    if (bus.win_ready) begin
                        if (bus.win_last) begin
                            lastCycle   = cycle;
                            lastWordIdx = outIdx;
                        end
                        outIdx++;
                    end
                end
                if (bus.done) begin
                    doneCnt++;
                    doneSeen = 1'b1;
                    if (expCount == 0) begin
                        checkOutput("done_after_start", 128'(cycle), 128'(startCycle + 1));
                    end else begin
                        checkOutput("done_after_last", 128'(cycle), 128'(lastCycle + 1));
                    end
                    checkOutput("words_at_done", 128'(outIdx), 128'(expCount));
                end
                rdEn2     = rdEn1;
                rdEn1     = bus.rd_en;
                popPrev   = bus.win_valid && bus.win_ready;
                prevStall = bus.win_valid && !bus.win_ready;
            end
        end
    end

    initial begin
        logic [31:0] firstAddr [9];
        int          n;
        checks       = 0;
        errors       = 0;
        trackEn      = 1'b0;
        readyMode    = 0;
        expCount     = 0;
        rst_n        = 1'b1;
        bus.start    = 1'b0;
        bus.IFM_C    = 16'd0;
        bus.IFM_W    = 16'd0;
        bus.padding  = 1'b0;
        bus.stride   = 1'b0;
        bus.row_done = 1'b0;
        firstAddr    = '{32'd0, 32'd4, 32'd8, 32'd24, 32'd28, 32'd32, 32'd48, 32'd52, 32'd56};

        repeat (3) tick();
        @(negedge clk);
        checkResetOutputs("reset");
        tick();
        rst_n = 1'b0;
        repeat (2) tick();

        $display("[TB] basic frame: C=16 W=4 pad=1 stride=1");
        applyStimulus(16, 4, 1, 0, 1'b1);
        sendRows(5);
        waitDone(3000);
        for (int i = 0; i < 9; i++) begin
            checkOutput("first_addr", 128'(obsAddr[i]), 128'(firstAddr[i]));
        end
        checkOutput("basic_words", 128'(outIdx), 128'(144));
        checkOutput("basic_last_idx", 128'(lastWordIdx), 128'(143));

        $display("[TB] row gating: C=32 W=4 pad=1");
        applyStimulus(32, 4, 1, 0, 1'b0);
        sendRows(2);
        repeat (30) tick();
        checkOutput("gate_two_rows", 128'(issueIdx), 128'(0));
        sendRows(1);
        repeat (200) tick();
        checkOutput("gate_oy0_reads", 128'(issueIdx), 128'(72));
        checkOutput("gate_busy", 128'(bus.busy), 128'(1));
        sendRows(1);
        repeat (60) tick();
        checkOutput("gate_oy1_started", 128'(issueIdx > 72), 128'(1));
        sendRows(2);
        waitDone(3000);
        checkOutput("gate_words", 128'(outIdx), 128'(288));

        $display("[TB] random backpressure: C=32 W=3 pad=1");
        readyMode = 1;
        applyStimulus(32, 3, 1, 0, 1'b1);
        sendRows(4);
        waitDone(6000);
        readyMode = 0;
        checkOutput("bp_words", 128'(outIdx), 128'(162));

        $display("[TB] stride 2: C=16 W=5 pad=1");
        applyStimulus(16, 5, 1, 1, 1'b0);
        sendRows(7);
        waitDone(3000);
        checkOutput("s2_words", 128'(outIdx), 128'(81));
        checkOutput("s2_ox1_addr", 128'(obsAddr[9]), 128'(8));
        checkOutput("s2_oy1_addr", 128'(obsAddr[27]), 128'(56));

        $display("[TB] reset mid-frame");
        applyStimulus(16, 4, 1, 0, 1'b0);
        sendRows(6);
        n = 0;
        while (outIdx < 20 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        #1;
        checkOutput("midreset_reached20", 128'(outIdx >= 20), 128'(1));
        rst_n   = 1'b1;
        trackEn = 1'b0;
        tick();
        rst_n = 1'b0;
        @(negedge clk);
        checkResetOutputs("midreset");
        repeat (3) tick();
        applyStimulus(16, 4, 1, 0, 1'b1);
        sendRows(5);
        waitDone(3000);
        checkOutput("after_reset_words", 128'(outIdx), 128'(144));
        checkOutput("after_reset_last_idx", 128'(lastWordIdx), 128'(143));

        $display("[TB] degenerate frame: W=1 pad=0");
        applyStimulus(16, 1, 0, 0, 1'b0);
        waitDone(20);
        checkOutput("degenerate_reads", 128'(issueIdx), 128'(0));
        checkOutput("degenerate_words", 128'(outIdx), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
